// File: rtl/writeback_result_unit_pkg.sv
// Shared encodings for the write-back stage: load sizes, FSM states and the
// alignment rule used when a load is accepted.
package writeback_result_unit_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_WRITE    = 2'd2
   } wb_state_t;

   // Size 2'b11 is handled as a word, so it shares the word alignment rule.
   function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         LS_BYTE: bad = 1'b0;
         LS_HALF: bad = offset[0];
         default: bad = (offset != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/writeback_result_unit_load_extend.sv
// Picks the addressed byte/half lane out of a little-endian word and sign- or
// zero-extends it to 32 bits.
module load_extend
   import writeback_result_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        zero_extend,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        byte_fill;
   logic        half_fill;

   always_comb begin
      byte_lane = word[7:0];
      case (offset)
         2'd0:    byte_lane = word[7:0];
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         default: byte_lane = word[31:24];
      endcase
      half_lane = offset[1] ? word[31:16] : word[15:0];
      byte_fill = ~zero_extend & byte_lane[7];
      half_fill = ~zero_extend & half_lane[15];

      result = word;
      case (size)
         LS_BYTE: result = {{24{byte_fill}}, byte_lane};
         LS_HALF: result = {{16{half_fill}}, half_lane};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/writeback_result_unit.sv
// Write-back stage: returns ALU results or extended memory loads to the
// register file, one instruction at a time, with alignment and timeout aborts.
module writeback_result_unit #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [31:0] ALU_Result,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic [1:0]  Load_Size,
   input  logic        Load_Unsigned,
   input  logic [4:0]  Write_Reg,
   output logic        Mem_Req,
   output logic [31:0] Mem_Addr,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_RData,
   output logic        Reg_Write_En,
   output logic [4:0]  Reg_Write_Addr,
   output logic [31:0] Reg_Write_Data,
   output logic        Align_Err,
   output logic        Timeout_Err
);

   import writeback_result_unit_pkg::*;

   wb_state_t        state;
   wb_state_t        state_next;

   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout_hit;
   logic             load_bad;

   logic             take_alu;
   logic             take_load;
   logic             take_bad;
   logic             mem_done;
   logic             mem_abort;

   logic [31:0]      mem_addr_q;
   logic [1:0]       pend_off;
   logic [1:0]       pend_size;
   logic             pend_uns;
   logic             pend_we;
   logic [4:0]       pend_reg;

   logic             wr_en_q;
   logic [4:0]       wr_addr_q;
   logic [31:0]      wr_data_q;
   logic             align_err_q;
   logic             timeout_err_q;
   logic [31:0]      ext_data;

   load_extend u_load_extend (
      .word        (Mem_RData),
      .offset      (pend_off),
      .size        (pend_size),
      .zero_extend (pend_uns),
      .result      (ext_data)
   );

   // cnt_inc is the number of WAIT_MEM cycles including the current one.
   assign cnt_inc     = wait_cnt + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
   assign load_bad    = load_misaligned(Load_Size, ALU_Result[1:0]);

   assign In_Ready       = (state == ST_IDLE) || (state == ST_WRITE);
   assign Mem_Req        = (state == ST_WAIT_MEM);
   assign Mem_Addr       = mem_addr_q;
   assign Reg_Write_En   = (state == ST_WRITE) && wr_en_q;
   assign Reg_Write_Addr = wr_addr_q;
   assign Reg_Write_Data = wr_data_q;
   assign Align_Err      = align_err_q;
   assign Timeout_Err    = timeout_err_q;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      take_alu   = 1'b0;
      take_load  = 1'b0;
      take_bad   = 1'b0;
      mem_done   = 1'b0;
      mem_abort  = 1'b0;
      case (state)
         ST_IDLE, ST_WRITE: begin
            state_next = ST_IDLE;
            if (In_Valid) begin
               if (!MemtoReg) begin
                  state_next = ST_WRITE;
                  take_alu   = 1'b1;
               end else if (load_bad) begin
                  take_bad = 1'b1;
               end else begin
                  state_next = ST_WAIT_MEM;
                  take_load  = 1'b1;
               end
            end
         end
         ST_WAIT_MEM: begin
            // An ack arriving on the timeout cycle still completes the load.
            if (Mem_Ack) begin
               state_next = ST_WRITE;
               mem_done   = 1'b1;
            end else if (timeout_hit) begin
               state_next = ST_IDLE;
               mem_abort  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         wait_cnt      <= '0;
         mem_addr_q    <= '0;
         pend_off      <= '0;
         pend_size     <= '0;
         pend_uns      <= 1'b0;
         pend_we       <= 1'b0;
         pend_reg      <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         align_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         align_err_q   <= take_bad;
         timeout_err_q <= mem_abort;
         wait_cnt      <= (state == ST_WAIT_MEM) ? cnt_inc : '0;

         if (take_load) begin
            mem_addr_q <= {ALU_Result[31:2], 2'b00};
            pend_off   <= ALU_Result[1:0];
            pend_size  <= Load_Size;
            pend_uns   <= Load_Unsigned;
            pend_we    <= RegWrite && (Write_Reg != REG_ZERO);
            pend_reg   <= Write_Reg;
         end

         // Write port registers only change when a new WRITE is entered.
         if (take_alu) begin
            wr_en_q   <= RegWrite && (Write_Reg != REG_ZERO);
            wr_addr_q <= Write_Reg;
            wr_data_q <= ALU_Result;
         end else if (mem_done) begin
            wr_en_q   <= pend_we;
            wr_addr_q <= pend_reg;
            wr_data_q <= ext_data;
         end
      end
   end

endmodule
